// File: rtl/mips_pkg.sv
// Shared MIPS pipeline definitions: register-index constants, datapath widths,
// the write-back entry record and the WB latch occupancy states.
package mips_pkg;

  localparam int DATA_W = 32;
  localparam int ADDR_W = 5;

  localparam logic [ADDR_W-1:0] REG_ZERO = 5'd0;
  localparam logic [ADDR_W-1:0] REG_RA   = 5'd31;

  // One write-back request as it travels from the destination-select mux
  // through MEM/WB into the register file.
  typedef struct packed {
    logic              valid;
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] data;
  } wb_entry_t;

  // Occupancy of the WB latch in front of the register array.
  typedef enum logic {
    WB_EMPTY = 1'b0,
    WB_FULL  = 1'b1
  } wb_state_e;

  // True when an index names the hardwired-zero register.
  function automatic logic is_reg_zero(input logic [ADDR_W-1:0] idx);
    return idx == REG_ZERO;
  endfunction

endpackage : mips_pkg

// File: rtl/regfile_array.sv
// General-purpose register storage: 2^ADDR_W x DATA_W words, cleared by an
// asynchronous reset, one synchronous write port and two combinational reads.
module regfile_array #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 5
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              we_i,
  input  logic [ADDR_W-1:0] waddr_i,
  input  logic [DATA_W-1:0] wdata_i,
  input  logic [ADDR_W-1:0] raddr_a_i,
  input  logic [ADDR_W-1:0] raddr_b_i,
  output logic [DATA_W-1:0] rdata_a_o,
  output logic [DATA_W-1:0] rdata_b_o
);

  localparam int DEPTH = 1 << ADDR_W;

  logic [DATA_W-1:0] mem_q [DEPTH];

  // Storage: whole array clears on reset, otherwise a single-word write per edge.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem_q[i] <= '0;
      end
    end else if (we_i) begin
      mem_q[waddr_i] <= wdata_i;
    end
  end

  // Read ports are plain asynchronous lookups; bypassing happens one level up.
  assign rdata_a_o = mem_q[raddr_a_i];
  assign rdata_b_o = mem_q[raddr_b_i];

endmodule : regfile_array

// File: rtl/regfile_wb.sv
// Write-back stage: a one-entry WB latch in front of the register array, with
// stall/flush control and read ports that forward the uncommitted entry.
module regfile_wb #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 5
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              wb_valid_i,
  input  logic [ADDR_W-1:0] wb_addr_i,
  input  logic [DATA_W-1:0] wb_data_i,
  input  logic              stall_i,
  input  logic              flush_i,
  input  logic [ADDR_W-1:0] rs_addr_i,
  input  logic [ADDR_W-1:0] rt_addr_i,
  output logic [DATA_W-1:0] rs_data_o,
  output logic [DATA_W-1:0] rt_data_o,
  output logic              wb_pending_o,
  output logic [ADDR_W-1:0] wb_pending_addr_o
);

  import mips_pkg::wb_state_e;
  import mips_pkg::WB_EMPTY;
  import mips_pkg::WB_FULL;
  import mips_pkg::REG_ZERO;

  localparam int NUM_RD = 2;
  localparam logic [ADDR_W-1:0] ZERO_IDX = ADDR_W'(REG_ZERO);

  // WB latch: occupancy is the FSM state, address/data ride alongside it.
  wb_state_e         state_q, state_d;
  logic [ADDR_W-1:0] lat_addr_q, lat_addr_d;
  logic [DATA_W-1:0] lat_data_q, lat_data_d;
  logic              lat_valid;

  // Commit path into the array.
  logic              commit_we;

  // Read port bundles, indexed 0 = rs, 1 = rt.
  logic [ADDR_W-1:0] rd_addr  [NUM_RD];
  logic [DATA_W-1:0] arr_data [NUM_RD];
  logic [DATA_W-1:0] rd_data  [NUM_RD];

  assign lat_valid = (state_q == WB_FULL);

  // Latch control: flush beats stall beats normal commit-and-reload.
  always_comb begin
    state_d    = state_q;
    lat_addr_d = lat_addr_q;
    lat_data_d = lat_data_q;
    commit_we  = 1'b0;
    if (flush_i) begin
      // Both the latched entry and the incoming one are dropped.
      state_d = WB_EMPTY;
    end else if (stall_i) begin
      // Hold everything; incoming entry is ignored.
      state_d = state_q;
    end else begin
      // Register 0 entries occupy the latch but never reach the array.
      commit_we  = lat_valid && (lat_addr_q != ZERO_IDX);
      state_d    = wb_valid_i ? WB_FULL : WB_EMPTY;
      lat_addr_d = wb_addr_i;
      lat_data_d = wb_data_i;
    end
  end

  // Latch registers; an uncommitted entry is lost on reset.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= WB_EMPTY;
      lat_addr_q <= '0;
      lat_data_q <= '0;
    end else begin
      state_q    <= state_d;
      lat_addr_q <= lat_addr_d;
      lat_data_q <= lat_data_d;
    end
  end

  regfile_array #(
    .DATA_W (DATA_W),
    .ADDR_W (ADDR_W)
  ) u_array (
    .clk       (clk),
    .rst       (rst),
    .we_i      (commit_we),
    .waddr_i   (lat_addr_q),
    .wdata_i   (lat_data_q),
    .raddr_a_i (rd_addr[0]),
    .raddr_b_i (rd_addr[1]),
    .rdata_a_o (arr_data[0]),
    .rdata_b_o (arr_data[1])
  );

  assign rd_addr[0] = rs_addr_i;
  assign rd_addr[1] = rt_addr_i;

  // Per-port bypass: zero register, then latched entry, then array contents.
  for (genvar gi = 0; gi < NUM_RD; gi++) begin : g_rd_port
    always_comb begin
      rd_data[gi] = arr_data[gi];
      if (rd_addr[gi] == ZERO_IDX) begin
        rd_data[gi] = '0;
      end else if (lat_valid && (rd_addr[gi] == lat_addr_q)) begin
        rd_data[gi] = lat_data_q;
      end
    end
  end

  assign rs_data_o         = rd_data[0];
  assign rt_data_o         = rd_data[1];
  assign wb_pending_o      = lat_valid;
  assign wb_pending_addr_o = lat_addr_q;

endmodule : regfile_wb

// File: tb/tb_regfile_wb.sv
// Directed bench for regfile_wb: a register-file model checked every cycle,
// plus literal expectations at the interesting points of each scenario.
module tb_regfile_wb;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        wb_valid_i = 1'b0;
  logic [4:0]  wb_addr_i = '0;
  logic [31:0] wb_data_i = '0;
  logic        stall_i = 1'b0;
  logic        flush_i = 1'b0;
  logic [4:0]  rs_addr_i = '0;
  logic [4:0]  rt_addr_i = '0;
  logic [31:0] rs_data_o, rt_data_o;
  logic        wb_pending_o;
  logic [4:0]  wb_pending_addr_o;

  int checks = 0;
  int failures = 0;

  regfile_wb #(.DATA_W(32), .ADDR_W(5)) dut (
    .clk               (clk),
    .rst               (rst),
    .wb_valid_i        (wb_valid_i),
    .wb_addr_i         (wb_addr_i),
    .wb_data_i         (wb_data_i),
    .stall_i           (stall_i),
    .flush_i           (flush_i),
    .rs_addr_i         (rs_addr_i),
    .rt_addr_i         (rt_addr_i),
    .rs_data_o         (rs_data_o),
    .rt_data_o         (rt_data_o),
    .wb_pending_o      (wb_pending_o),
    .wb_pending_addr_o (wb_pending_addr_o)
  );

  always #5 clk = ~clk;

  // Model: architectural registers plus the one pending write.
  logic [31:0] m_regs [32];
  logic        m_pend;
  logic [4:0]  m_paddr;
  logic [31:0] m_pdata;

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      foreach (m_regs[i]) m_regs[i] = 32'h0;
      m_pend = 1'b0; m_paddr = 5'd0; m_pdata = 32'h0;
    end else if (flush_i) begin
      m_pend = 1'b0;
    end else if (!stall_i) begin
      if (m_pend && m_paddr != 5'd0) m_regs[m_paddr] = m_pdata;
      m_pend = wb_valid_i; m_paddr = wb_addr_i; m_pdata = wb_data_i;
    end
  end

  function automatic logic [31:0] m_read(input logic [4:0] a);
    if (a == 5'd0) return 32'h0;
    if (m_pend && a == m_paddr) return m_pdata;
    return m_regs[a];
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %08h expected %08h at %0t", name, act, exp, $time);
    end
  endtask

  // Every-cycle comparison against the model, away from the active edge.
  always @(negedge clk) begin
    if (!rst) begin
      chk("model_rs", rs_data_o, m_read(rs_addr_i));
      chk("model_rt", rt_data_o, m_read(rt_addr_i));
      chk("model_pending", {31'h0, wb_pending_o}, {31'h0, m_pend});
      chk("model_pending_addr", {27'h0, wb_pending_addr_o}, {27'h0, m_paddr});
    end
  end

  // Present inputs, let one edge sample them, return shortly after the edge.
  task automatic cyc(input logic v, input logic [4:0] a, input logic [31:0] d,
                     input logic st, input logic fl, input logic [4:0] rs, input logic [4:0] rt);
    wb_valid_i = v; wb_addr_i = a; wb_data_i = d;
    stall_i = st; flush_i = fl; rs_addr_i = rs; rt_addr_i = rt;
    @(posedge clk);
    #1;
    $display("cyc v=%0b a=%0d d=%08h st=%0b fl=%0b | rs[%0d]=%08h rt[%0d]=%08h pend=%0b@%0d",
             v, a, d, st, fl, rs, rs_data_o, rt, rt_data_o, wb_pending_o, wb_pending_addr_o);
  endtask

  initial begin
    // Reset state.
    rs_addr_i = 5'd5; rt_addr_i = 5'd31;
    @(posedge clk); #1;
    chk("reset_rs", rs_data_o, 32'h0);
    chk("reset_rt", rt_data_o, 32'h0);
    chk("reset_pending", {31'h0, wb_pending_o}, 32'h0);
    @(posedge clk); #1;
    rst = 1'b0;

    // Write, bypass, commit.
    cyc(1'b1, 5'd7, 32'hDEADBEEF, 1'b0, 1'b0, 5'd7, 5'd7);
    chk("bypass7_rs", rs_data_o, 32'hDEADBEEF);
    chk("bypass7_pend", {31'h0, wb_pending_o}, 32'h1);
    chk("bypass7_paddr", {27'h0, wb_pending_addr_o}, 32'd7);
    cyc(1'b0, 5'd0, 32'h0, 1'b0, 1'b0, 5'd7, 5'd7);
    chk("commit7_rt", rt_data_o, 32'hDEADBEEF);
    chk("commit7_pend", {31'h0, wb_pending_o}, 32'h0);

    // Register 0 write.
    cyc(1'b1, 5'd0, 32'h12345678, 1'b0, 1'b0, 5'd0, 5'd7);
    chk("r0_pend", {31'h0, wb_pending_o}, 32'h1);
    chk("r0_read", rs_data_o, 32'h0);
    chk("r0_other", rt_data_o, 32'hDEADBEEF);
    cyc(1'b0, 5'd0, 32'h0, 1'b0, 1'b0, 5'd0, 5'd7);
    chk("r0_after", rs_data_o, 32'h0);
    chk("r0_pend_clr", {31'h0, wb_pending_o}, 32'h0);

    // Stall hold on register 31.
    cyc(1'b1, 5'd31, 32'hA5A5A5A5, 1'b0, 1'b0, 5'd7, 5'd31);
    for (int k = 0; k < 3; k++) begin
      cyc(1'b1, 5'd31, 32'h1, 1'b1, 1'b0, 5'd7, 5'd31);
      chk("stall_rt", rt_data_o, 32'hA5A5A5A5);
      chk("stall_pend", {31'h0, wb_pending_o}, 32'h1);
    end
    cyc(1'b0, 5'd0, 32'h0, 1'b0, 1'b0, 5'd31, 5'd31);
    chk("stall_commit", rs_data_o, 32'hA5A5A5A5);
    chk("stall_commit_pend", {31'h0, wb_pending_o}, 32'h0);

    // Flush while stalled.
    cyc(1'b1, 5'd9, 32'h55, 1'b0, 1'b0, 5'd9, 5'd31);
    chk("flush_pre", rs_data_o, 32'h55);
    cyc(1'b1, 5'd9, 32'h77, 1'b1, 1'b1, 5'd9, 5'd31);
    chk("flush_pend", {31'h0, wb_pending_o}, 32'h0);
    chk("flush_r9", rs_data_o, 32'h0);
    cyc(1'b0, 5'd0, 32'h0, 1'b0, 1'b0, 5'd9, 5'd31);
    chk("flush_r9_late", rs_data_o, 32'h0);
    chk("flush_r31", rt_data_o, 32'hA5A5A5A5);

    // Back-to-back writes to register 3.
    cyc(1'b1, 5'd3, 32'h11, 1'b0, 1'b0, 5'd3, 5'd3);
    chk("b2b_first", rs_data_o, 32'h11);
    cyc(1'b1, 5'd3, 32'h22, 1'b0, 1'b0, 5'd3, 5'd3);
    chk("b2b_second", rt_data_o, 32'h22);
    cyc(1'b0, 5'd0, 32'h0, 1'b0, 1'b0, 5'd3, 5'd7);
    chk("b2b_final", rs_data_o, 32'h22);
    chk("b2b_other", rt_data_o, 32'hDEADBEEF);
    cyc(1'b0, 5'd0, 32'h0, 1'b0, 1'b0, 5'd3, 5'd3);
    chk("b2b_final2", rt_data_o, 32'h22);

    // Reset mid-run with an uncommitted entry.
    cyc(1'b1, 5'd5, 32'hABCD0123, 1'b0, 1'b0, 5'd5, 5'd31);
    chk("mid_pre", rs_data_o, 32'hABCD0123);
    rst = 1'b1;
    #1;
    chk("mid_rs", rs_data_o, 32'h0);
    chk("mid_rt", rt_data_o, 32'h0);
    chk("mid_pend", {31'h0, wb_pending_o}, 32'h0);
    cyc(1'b0, 5'd0, 32'h0, 1'b0, 1'b0, 5'd7, 5'd3);
    rst = 1'b0;
    cyc(1'b0, 5'd0, 32'h0, 1'b0, 1'b0, 5'd7, 5'd3);
    chk("post_r7", rs_data_o, 32'h0);
    chk("post_r3", rt_data_o, 32'h0);
    cyc(1'b0, 5'd0, 32'h0, 1'b0, 1'b0, 5'd5, 5'd31);
    chk("post_r5", rs_data_o, 32'h0);
    chk("post_r31", rt_data_o, 32'h0);

    @(negedge clk);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule : tb_regfile_wb
